// File: rtl/tile_color_rotator_if.sv
// Pixel-path bundle between the VGA timing generator, the tile colour rotator and the RGB pins.
// visible qualifies each pixel; the stream has no backpressure, so there is no ready signal.
interface tile_color_rotator_if #(
    parameter int COLOR_W = 8
);
    logic [9:0]         xOrd;
    logic [9:0]         yOrd;
    logic               visible;
    logic               frame_start;
    logic [1:0]         mode;
    logic               dir;
    logic               pause;
    logic               step;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    logic [1:0]         rot_idx;

    modport master (
        output xOrd, yOrd, visible, frame_start, mode, dir, pause, step,
        input  red, green, blue, rot_idx
    );

    modport slave (
        input  xOrd, yOrd, visible, frame_start, mode, dir, pause, step,
        output red, green, blue, rot_idx
    );
endinterface

// File: rtl/tile_color_rotator.sv
// Tile-pattern colour generator: maps each pixel to a 4-entry palette by tile position and
// pattern mode, rotating the palette at ROT_HZ with tear-free commits at frame start.
module tile_color_rotator #(
    parameter int CLK_HZ  = 50000000,
    parameter int ROT_HZ  = 1,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int TILES_X = 2,
    parameter int TILES_Y = 2,
    parameter int COLOR_W = 8
) (
    input logic clk,
    input logic rst_n,
    tile_color_rotator_if.slave px
);
    localparam int TICK_N = CLK_HZ / ROT_HZ;
    localparam int CNT_W  = $clog2(TICK_N);
    localparam int TILE_W = H_RES / TILES_X;
    localparam int TILE_H = V_RES / TILES_Y;
    localparam logic [1:0] TX_M4 = 2'(TILES_X % 4);
    localparam logic [COLOR_W-1:0] C_ON  = '1;
    localparam logic [COLOR_W-1:0] C_OFF = '0;

    logic [CNT_W-1:0]   cnt_q;
    logic               pending_q;
    logic [1:0]         rot_q;
    logic [1:0]         mode_q;
    logic               dir_q;
    logic [COLOR_W-1:0] red_q, green_q, blue_q;

    logic               tick;
    logic               req;
    logic [9:0]         tx_raw, ty_raw;
    logic [1:0]         tx, ty;
    logic [1:0]         pal_idx;
    logic [COLOR_W-1:0] red_d, green_d, blue_d;

    assign tick = !px.pause && (cnt_q == CNT_W'(TICK_N - 1));
    assign req  = tick || (px.step && px.pause);

    // Only the low two bits of the tile coordinates matter: every palette sum is taken mod 4.
    always_comb begin
        tx_raw = px.xOrd / 10'(TILE_W);
        ty_raw = px.yOrd / 10'(TILE_H);
        tx     = (tx_raw > 10'(TILES_X - 1)) ? 2'((TILES_X - 1) % 4) : tx_raw[1:0];
        ty     = (ty_raw > 10'(TILES_Y - 1)) ? 2'((TILES_Y - 1) % 4) : ty_raw[1:0];
        case (mode_q)
            2'd0:    pal_idx = 2'(ty * TX_M4) + tx + rot_q;
            2'd1:    pal_idx = tx + ty + rot_q;
            2'd2:    pal_idx = ty + rot_q;
            default: pal_idx = rot_q;
        endcase
    end

    always_comb begin
        red_d   = C_OFF;
        green_d = C_OFF;
        blue_d  = C_OFF;
        if (px.visible) begin
            case (pal_idx)
                2'd0:    green_d = C_ON;
                2'd1:    begin red_d = C_ON; green_d = C_ON; end
                2'd2:    red_d = C_ON;
                default: blue_d = C_ON;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
            rot_q     <= 2'd0;
            mode_q    <= 2'd0;
            dir_q     <= 1'b0;
            red_q     <= C_OFF;
            green_q   <= C_OFF;
            blue_q    <= C_OFF;
        end else begin
            if (!px.pause) cnt_q <= tick ? '0 : cnt_q + 1'b1;
            // The rotation at a frame start still uses the previous frame's direction.
            if (px.frame_start) begin
                if (pending_q || req) rot_q <= dir_q ? rot_q - 2'd1 : rot_q + 2'd1;
                pending_q <= 1'b0;
                mode_q    <= px.mode;
                dir_q     <= px.dir;
            end else if (req) begin
                pending_q <= 1'b1;
            end
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign px.red     = red_q;
    assign px.green   = green_q;
    assign px.blue    = blue_q;
    assign px.rot_idx = rot_q;
endmodule

// File: tb/tb_tile_color_rotator.sv
// Bench for tile_color_rotator: a 2x2 and a 4x4 instance share one stimulus stream and are
// checked against an arithmetic reference model of the palette, rotation and commit rules.
module tb_tile_color_rotator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tile_color_rotator_if #(.COLOR_W(8)) bus_a ();
    tile_color_rotator_if #(.COLOR_W(8)) bus_b ();

    assign bus_b.xOrd        = bus_a.xOrd;
    assign bus_b.yOrd        = bus_a.yOrd;
    assign bus_b.visible     = bus_a.visible;
    assign bus_b.frame_start = bus_a.frame_start;
    assign bus_b.mode        = bus_a.mode;
    assign bus_b.dir         = bus_a.dir;
    assign bus_b.pause       = bus_a.pause;
    assign bus_b.step        = bus_a.step;

    tile_color_rotator #(.CLK_HZ(16), .ROT_HZ(1), .H_RES(640), .V_RES(480),
                         .TILES_X(2), .TILES_Y(2), .COLOR_W(8))
        dut_a (.clk(clk), .rst_n(rst_n), .px(bus_a.slave));

    tile_color_rotator #(.CLK_HZ(16), .ROT_HZ(1), .H_RES(640), .V_RES(480),
                         .TILES_X(4), .TILES_Y(4), .COLOR_W(8))
        dut_b (.clk(clk), .rst_n(rst_n), .px(bus_b.slave));

    logic [23:0] rgb_a, rgb_b;
    assign rgb_a = {bus_a.red, bus_a.green, bus_a.blue};
    assign rgb_b = {bus_b.red, bus_b.green, bus_b.blue};

    localparam logic [23:0] GREEN  = 24'h00FF00;
    localparam logic [23:0] YELLOW = 24'hFFFF00;
    localparam logic [23:0] RED    = 24'hFF0000;
    localparam logic [23:0] BLUE   = 24'h0000FF;

    // Reference model state
    int          m_phase, m_rot, m_mode;
    bit          m_dir, m_pend;
    logic [23:0] exp_a, exp_b;
    int          n_cmp = 0;
    int          n_fail = 0;

    function automatic logic [23:0] ref_color(int x, int y, bit vis, int rot, int mode,
                                              int ntx, int nty);
        int tx, ty, idx;
        if (!vis) return 24'h0;
        tx = x / (640 / ntx);
        ty = y / (480 / nty);
        if (tx > ntx - 1) tx = ntx - 1;
        if (ty > nty - 1) ty = nty - 1;
        case (mode)
            0:       idx = ty * ntx + tx + rot;
            1:       idx = tx + ty + rot;
            2:       idx = ty + rot;
            default: idx = rot;
        endcase
        case (idx % 4)
            0:       return GREEN;
            1:       return YELLOW;
            2:       return RED;
            default: return BLUE;
        endcase
    endfunction

    // One clock: predict the registered outputs, advance the model, then sample after the edge.
    task automatic cycle();
        bit tick, req;
        exp_a = rst_n ? ref_color(int'(bus_a.xOrd), int'(bus_a.yOrd), bus_a.visible,
                                  m_rot, m_mode, 2, 2) : 24'h0;
        exp_b = rst_n ? ref_color(int'(bus_a.xOrd), int'(bus_a.yOrd), bus_a.visible,
                                  m_rot, m_mode, 4, 4) : 24'h0;
        if (!rst_n) begin
            m_phase = 0; m_rot = 0; m_mode = 0; m_dir = 0; m_pend = 0;
        end else begin
            tick = !bus_a.pause && (m_phase == 15);
            req  = tick || (bus_a.step && bus_a.pause);
            if (!bus_a.pause) m_phase = (m_phase + 1) % 16;
            if (bus_a.frame_start) begin
                if (m_pend || req) m_rot = m_dir ? (m_rot + 3) % 4 : (m_rot + 1) % 4;
                m_pend = 0;
                m_mode = int'(bus_a.mode);
                m_dir  = bus_a.dir;
            end else if (req) begin
                m_pend = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_px(int x, int y, bit vis);
        bus_a.xOrd    = 10'(x);
        bus_a.yOrd    = 10'(y);
        bus_a.visible = vis;
    endtask

    task automatic pulse_frame();
        bus_a.frame_start = 1'b1;
        cycle();
        bus_a.frame_start = 1'b0;
    endtask

    task automatic pulse_step();
        bus_a.step = 1'b1;
        cycle();
        bus_a.step = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus_a.frame_start = 1'b0; bus_a.step = 1'b0; bus_a.pause = 1'b0;
        bus_a.mode = 2'd0; bus_a.dir = 1'b0;
        drive_px(0, 0, 1'b0);
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_px(400, 300, 1'b1);
        cycle();
        cycle();
        n_cmp++;
        if (bus_a.rot_idx !== 2'd0) begin
            n_fail++; $display("FAIL reset_rot: got %0d expected 0", bus_a.rot_idx);
        end
        n_cmp++;
        if (rgb_a !== 24'h0 || rgb_b !== 24'h0) begin
            n_fail++; $display("FAIL reset_rgb: got %h/%h expected 000000", rgb_a, rgb_b);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_quadrants();
        int          xs[4] = '{0, 400, 0, 400};
        int          ys[4] = '{0, 0, 300, 300};
        logic [23:0] cs[4] = '{GREEN, YELLOW, RED, BLUE};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive_px(xs[i], ys[i], 1'b1);
            cycle();
            n_cmp++;
            if (rgb_a !== cs[i]) begin
                n_fail++;
                $display("FAIL quadrant_%0d: got %h expected %h", i, rgb_a, cs[i]);
            end
        end
        drive_px(400, 300, 1'b0);
        cycle();
        n_cmp++;
        if (rgb_a !== 24'h0) begin
            n_fail++; $display("FAIL blanking: got %h expected 000000", rgb_a);
        end
        for (int i = 0; i < 8; i++) begin
            drive_px(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b1);
            cycle();
            n_cmp++;
            if (rgb_a !== exp_a || rgb_b !== exp_b) begin
                n_fail++;
                $display("FAIL quad_random: got %h/%h expected %h/%h", rgb_a, rgb_b, exp_a, exp_b);
            end
        end
    endtask

    task automatic test_rotation();
        apply_reset();
        drive_px(0, 0, 1'b1);
        repeat (40) cycle();
        n_cmp++;
        if (bus_a.rot_idx !== 2'd0) begin
            n_fail++; $display("FAIL rot_before_frame: got %0d expected 0", bus_a.rot_idx);
        end
        pulse_frame();
        n_cmp++;
        if (bus_a.rot_idx !== 2'd1) begin
            n_fail++; $display("FAIL rot_single_advance: got %0d expected 1", bus_a.rot_idx);
        end
        cycle();
        n_cmp++;
        if (rgb_a !== YELLOW) begin
            n_fail++; $display("FAIL rot_origin_colour: got %h expected %h", rgb_a, YELLOW);
        end
    endtask

    task automatic test_direction();
        logic [1:0] want[3] = '{2'd1, 2'd0, 2'd3};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            repeat (20) cycle();
            bus_a.dir = 1'b1;
            pulse_frame();
            n_cmp++;
            if (bus_a.rot_idx !== want[i]) begin
                n_fail++;
                $display("FAIL dir_step_%0d: got %0d expected %0d", i, bus_a.rot_idx, want[i]);
            end
        end
        bus_a.dir = 1'b0;
    endtask

    task automatic test_pause();
        apply_reset();
        bus_a.pause = 1'b1;
        repeat (100) cycle();
        pulse_frame();
        pulse_frame();
        n_cmp++;
        if (bus_a.rot_idx !== 2'd0) begin
            n_fail++; $display("FAIL pause_hold: got %0d expected 0", bus_a.rot_idx);
        end
        pulse_step();
        pulse_step();
        pulse_frame();
        n_cmp++;
        if (bus_a.rot_idx !== 2'd1) begin
            n_fail++; $display("FAIL pause_step: got %0d expected 1", bus_a.rot_idx);
        end
        bus_a.pause = 1'b0;
        pulse_step();
        pulse_frame();
        n_cmp++;
        if (bus_a.rot_idx !== 2'd1) begin
            n_fail++; $display("FAIL step_unpaused: got %0d expected 1", bus_a.rot_idx);
        end
    endtask

    task automatic test_tiles();
        apply_reset();
        drive_px(639, 479, 1'b1);
        cycle();
        n_cmp++;
        if (rgb_b !== BLUE) begin
            n_fail++; $display("FAIL tile15: got %h expected %h", rgb_b, BLUE);
        end
        drive_px(700, 0, 1'b1);
        cycle();
        n_cmp++;
        if (rgb_b !== BLUE) begin
            n_fail++; $display("FAIL x_clamp: got %h expected %h", rgb_b, BLUE);
        end
        bus_a.mode = 2'd2;
        drive_px(0, 130, 1'b1);
        cycle();
        cycle();
        n_cmp++;
        if (rgb_b !== GREEN) begin
            n_fail++; $display("FAIL mode_uncommitted: got %h expected %h", rgb_b, GREEN);
        end
        pulse_frame();
        cycle();
        n_cmp++;
        if (rgb_b !== YELLOW || rgb_a !== exp_a) begin
            n_fail++;
            $display("FAIL mode_bars: got %h/%h expected %h/%h", rgb_b, rgb_a, YELLOW, exp_a);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        repeat (15) cycle();
        pulse_frame();
        n_cmp++;
        if (bus_a.rot_idx !== 2'd1) begin
            n_fail++; $display("FAIL tick_same_cycle: got %0d expected 1", bus_a.rot_idx);
        end
        drive_px(400, 300, 1'b1);
        cycle();
        rst_n = 1'b0;
        cycle();
        n_cmp++;
        if (bus_a.rot_idx !== 2'd0 || rgb_a !== 24'h0) begin
            n_fail++;
            $display("FAIL midframe_reset: got rot %0d rgb %h expected rot 0 rgb 000000",
                     bus_a.rot_idx, rgb_a);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            drive_px(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                     $urandom_range(0, 3) != 0);
            bus_a.frame_start = ($urandom_range(0, 19) == 0);
            bus_a.mode        = 2'($urandom_range(0, 3));
            bus_a.dir         = 1'($urandom_range(0, 1));
            bus_a.pause       = ($urandom_range(0, 9) < 2);
            bus_a.step        = ($urandom_range(0, 7) == 0);
            cycle();
            n_cmp++;
            if (rgb_a !== exp_a || rgb_b !== exp_b || bus_a.rot_idx !== 2'(m_rot)) begin
                n_fail++;
                $display("FAIL random_%0d: got %h/%h rot %0d expected %h/%h rot %0d",
                         i, rgb_a, rgb_b, bus_a.rot_idx, exp_a, exp_b, m_rot);
            end
        end
        bus_a.frame_start = 1'b0; bus_a.pause = 1'b0; bus_a.step = 1'b0;
    endtask

    initial begin
        bus_a.xOrd = '0; bus_a.yOrd = '0; bus_a.visible = 1'b0;
        bus_a.frame_start = 1'b0; bus_a.mode = 2'd0; bus_a.dir = 1'b0;
        bus_a.pause = 1'b0; bus_a.step = 1'b0;
        m_phase = 0; m_rot = 0; m_mode = 0; m_dir = 0; m_pend = 0;
        exp_a = '0; exp_b = '0;
        #2;
        test_reset();
        test_quadrants();
        test_rotation();
        test_direction();
        test_pause();
        test_tiles();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
